// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits of a+b+cin per clock, carry held in a flop.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port that computes a-b instead.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N < 2) ? 1 : $clog2(N + 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_r;
    logic             carry, cout_r, ovf_r, done_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   step_sum;
    logic [WIDTH-1:0] sum_shift;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;
    logic             msb_cin;
    logic             last;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; cin has no meaning in that mode.
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub ? 1'b1 : cin;
`else
    assign b_ld = b;
    assign c_ld = cin;
`endif

    assign step_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry};
    // Carry into the top bit of this digit, recovered from its sum bit.
    assign msb_cin  = step_sum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
    assign last     = (cnt == CW'(N - 1));

    generate
        if (WIDTH == DIGIT) begin : g_one_digit
            assign sum_shift = step_sum[DIGIT-1:0];
        end else begin : g_multi_digit
            assign sum_shift = {step_sum[DIGIT-1:0], sum_r[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sh  <= a;
                    b_sh  <= b_ld;
                    carry <= c_ld;
                    cnt   <= '0;
                end
            end else begin
                a_sh  <= a_sh >> DIGIT;
                b_sh  <= b_sh >> DIGIT;
                sum_r <= sum_shift;
                carry <= step_sum[DIGIT];
                cnt   <= cnt + CW'(1);
                if (last) begin
                    cout_r <= step_sum[DIGIT];
                    ovf_r  <= msb_cin ^ step_sum[DIGIT];
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign busy     = (state == RUN);
    assign done     = done_r;
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three instances (16x1, 1x1, 16x4 digit).
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int pass = 0;
    int total = 0;

    // p: WIDTH=16 DIGIT=1, f: WIDTH=1 DIGIT=1, q: WIDTH=16 DIGIT=4
    logic        st_p = 0, ci_p = 0, busy_p, done_p, co_p, ov_p;
    logic [15:0] a_p = 0, b_p = 0, sum_p;
    logic        st_f = 0, ci_f = 0, busy_f, done_f, co_f, ov_f;
    logic [0:0]  a_f = 0, b_f = 0, sum_f;
    logic        st_q = 0, ci_q = 0, busy_q, done_q, co_q, ov_q;
    logic [15:0] a_q = 0, b_q = 0, sum_q;
`ifdef SERIAL_ADDER_SUB_EN
    logic        sub = 1'b0;
`endif

    serial_adder #(.WIDTH(16), .DIGIT(1)) u_p (
        .clk(clk), .rst_n(rst_n), .start(st_p), .a(a_p), .b(b_p), .cin(ci_p),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_p), .done(done_p), .sum(sum_p), .cout(co_p), .overflow(ov_p));

    serial_adder #(.WIDTH(1), .DIGIT(1)) u_f (
        .clk(clk), .rst_n(rst_n), .start(st_f), .a(a_f), .b(b_f), .cin(ci_f),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_f), .done(done_f), .sum(sum_f), .cout(co_f), .overflow(ov_f));

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_q (
        .clk(clk), .rst_n(rst_n), .start(st_q), .a(a_q), .b(b_q), .cin(ci_q),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_q), .done(done_q), .sum(sum_q), .cout(co_q), .overflow(ov_q));

    // Full-adder truth table {cout,sum}, indexed by {a,b,cin}.
    localparam bit [1:0] FA_EXP [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                                        2'b01, 2'b10, 2'b10, 2'b11};

    task automatic drive(input int sel, input logic s, input logic [15:0] av,
                         input logic [15:0] bv, input logic ci);
        case (sel)
            0:       begin st_p = s; a_p = av;    b_p = bv;    ci_p = ci; end
            1:       begin st_f = s; a_f = av[0]; b_f = bv[0]; ci_f = ci; end
            default: begin st_q = s; a_q = av;    b_q = bv;    ci_q = ci; end
        endcase
    endtask

    // Launch one op and wait (bounded) for done; lat=-1 on timeout.
    task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, output int lat, output bit busy_ok);
        logic d, bz;
        lat = -1;
        drive(sel, 1'b1, av, bv, ci);
        @(posedge clk); #1;
        drive(sel, 1'b0, av, bv, ci);
        case (sel)
            0: bz = busy_p; 1: bz = busy_f; default: bz = busy_q;
        endcase
        busy_ok = bz;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            case (sel)
                0:       begin d = done_p; bz = busy_p; end
                1:       begin d = done_f; bz = busy_f; end
                default: begin d = done_q; bz = busy_q; end
            endcase
            if (d) begin
                lat = i;
                if (bz) busy_ok = 0;
                break;
            end
            if (!bz) busy_ok = 0;
        end
    endtask

    task automatic test_reset;
        #3;
        total++; if ({busy_p, done_p, sum_p, co_p, ov_p} !== '0)
            $display("FAIL reset_p got=%h exp=0", {busy_p, done_p, sum_p, co_p, ov_p}); else pass++;
        total++; if ({busy_f, done_f, sum_f, co_f, ov_f} !== '0)
            $display("FAIL reset_f got=%h exp=0", {busy_f, done_f, sum_f, co_f, ov_f}); else pass++;
        total++; if ({busy_q, done_q, sum_q, co_q, ov_q} !== '0)
            $display("FAIL reset_q got=%h exp=0", {busy_q, done_q, sum_q, co_q, ov_q}); else pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_d1;
        int lat; bit bok;
        run_op(0, 16'h0001, 16'hFFFF, 1'b0, lat, bok);
        total++; if (lat !== 16) $display("FAIL add1_latency got=%0d exp=16", lat); else pass++;
        total++; if (!bok) $display("FAIL add1_busy got=bad exp=busy_until_done"); else pass++;
        total++; if ({sum_p, co_p, ov_p} !== {16'h0000, 1'b1, 1'b0})
            $display("FAIL add1_result got=%h/%b/%b exp=0000/1/0", sum_p, co_p, ov_p); else pass++;
        @(posedge clk); #1;
        total++; if ({done_p, busy_p} !== 2'b00)
            $display("FAIL add1_done_pulse got=%b exp=00", {done_p, busy_p}); else pass++;
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, lat, bok);
        total++; if ({sum_p, co_p, ov_p} !== {16'h8000, 1'b0, 1'b1} || lat !== 16)
            $display("FAIL add2_result got=%h/%b/%b lat=%0d exp=8000/0/1 lat=16", sum_p, co_p, ov_p, lat); else pass++;
        run_op(0, 16'h8000, 16'h8000, 1'b0, lat, bok);
        total++; if ({sum_p, co_p, ov_p} !== {16'h0000, 1'b1, 1'b1} || lat !== 16)
            $display("FAIL add3_result got=%h/%b/%b lat=%0d exp=0000/1/1 lat=16", sum_p, co_p, ov_p, lat); else pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_full_adder;
        int lat; bit bok;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            run_op(1, {15'd0, v[2]}, {15'd0, v[1]}, v[0], lat, bok);
            total++; if (lat !== 1 || !bok)
                $display("FAIL fa_latency_%0d got=%0d busy_ok=%0d exp=1", i, lat, bok); else pass++;
            total++; if ({co_f, sum_f} !== FA_EXP[i])
                $display("FAIL fa_result_%0d got=%b exp=%b", i, {co_f, sum_f}, FA_EXP[i]); else pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_digit4;
        int lat = -1;
        drive(2, 1'b1, 16'h1234, 16'h0FFF, 1'b1);
        @(posedge clk); #1;
        drive(2, 1'b0, 16'h1234, 16'h0FFF, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done_q) begin lat = i; break; end
            // Stray start while running must be ignored.
            if (i == 1) drive(2, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
            else        drive(2, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        end
        total++; if (lat !== 4) $display("FAIL d4_latency got=%0d exp=4", lat); else pass++;
        total++; if ({sum_q, co_q, ov_q} !== {16'h2234, 1'b0, 1'b0})
            $display("FAIL d4_result got=%h/%b/%b exp=2234/0/0", sum_q, co_q, ov_q); else pass++;
        @(posedge clk); #1;
        total++; if ({busy_q, done_q, sum_q} !== {1'b0, 1'b0, 16'h2234})
            $display("FAIL d4_idle_after got=%b%b/%h exp=00/2234", busy_q, done_q, sum_q); else pass++;
    endtask

    task automatic test_reset_mid_op;
        int lat; bit bok, seen;
        run_op(0, 16'h7FFF, 16'h8000, 1'b0, lat, bok);
        total++; if ({sum_p, co_p, ov_p} !== {16'hFFFF, 1'b0, 1'b0})
            $display("FAIL pre_rst_result got=%h/%b/%b exp=FFFF/0/0", sum_p, co_p, ov_p); else pass++;
        drive(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++; if ({busy_p, done_p, sum_p, co_p, ov_p} !== '0)
            $display("FAIL mid_rst_state got=%b%b/%h/%b/%b exp=00/0000/0/0", busy_p, done_p, sum_p, co_p, ov_p); else pass++;
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done_p || busy_p) seen = 1;
        end
        total++; if (seen) $display("FAIL mid_rst_no_done got=activity exp=quiet"); else pass++;
        run_op(0, 16'h0003, 16'h0004, 1'b0, lat, bok);
        total++; if ({sum_p, co_p, ov_p} !== {16'h0007, 1'b0, 1'b0} || lat !== 16)
            $display("FAIL post_rst_result got=%h/%b/%b lat=%0d exp=0007/0/0 lat=16", sum_p, co_p, ov_p, lat); else pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat = -1, lat2 = -1;
        drive(2, 1'b1, 16'h00FF, 16'h0001, 1'b0);
        @(posedge clk); #1;
        drive(2, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done_q) begin lat = i; break; end
        end
        total++; if ({sum_q, co_q} !== {16'h0100, 1'b0} || lat !== 4)
            $display("FAIL b2b_first got=%h/%b lat=%0d exp=0100/0 lat=4", sum_q, co_q, lat); else pass++;
        @(posedge clk); #1;
        drive(2, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        total++; if ({busy_q, done_q} !== 2'b10)
            $display("FAIL b2b_relaunch got=%b exp=10", {busy_q, done_q}); else pass++;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done_q) begin lat2 = i; break; end
        end
        total++; if ({sum_q, co_q, ov_q} !== {16'h0000, 1'b1, 1'b0} || lat2 !== 4)
            $display("FAIL b2b_second got=%h/%b/%b lat=%0d exp=0000/1/0 lat=4", sum_q, co_q, ov_q, lat2); else pass++;
        @(posedge clk); #1;
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int lat; bit bok;
        sub = 1'b1;
        run_op(0, 16'h0005, 16'h0007, 1'b0, lat, bok);
        total++; if ({sum_p, co_p, ov_p} !== {16'hFFFE, 1'b0, 1'b0})
            $display("FAIL sub1 got=%h/%b/%b exp=FFFE/0/0", sum_p, co_p, ov_p); else pass++;
        run_op(0, 16'h8000, 16'h0001, 1'b1, lat, bok);
        total++; if ({sum_p, co_p, ov_p} !== {16'h7FFF, 1'b1, 1'b1})
            $display("FAIL sub2 got=%h/%b/%b exp=7FFF/1/1", sum_p, co_p, ov_p); else pass++;
        sub = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset;
        test_add_d1;
        test_full_adder;
        test_digit4;
        test_reset_mid_op;
        test_back_to_back;
`ifdef SERIAL_ADDER_SUB_EN
        test_sub;
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
